rgb_hue_sequencer: RTL and testbench

- Generates the three 8-bit duty values that feed the RGB LED PWM channels. Replaces today's constant duty wires with a continuously fading colour wheel.
- Walks the hue wheel in 6 linear phases of 255 steps each, 1530 steps per revolution. Exactly one channel changes by 1 LSB per step.
- Applies a global brightness scale, a pause (en) and a blanking override to the outputs.
- Runs on the board oscillator clock, same domain as the PWM generators.

---
 rtl/rgb_hue_sequencer_if.sv | 22 ++
 rtl/rgb_hue_sequencer.sv | 102 ++++++++++
 tb/tb_rgb_hue_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rgb_hue_sequencer_if.sv
// Control and duty-output bundle between the hue sequencer and its user.
// The master drives en/blank/bright, and the slave returns duty, phase and the step strobe.
interface rgb_hue_sequencer_if;
  logic       en;
  logic       blank;
  logic [7:0] bright;
  logic [7:0] duty_r;
  logic [7:0] duty_g;
  logic [7:0] duty_b;
  logic [2:0] phase;
  logic       step_stb;

  modport master (
    output en, blank, bright,
    input  duty_r, duty_g, duty_b, phase, step_stb
  );

  modport slave (
    input  en, blank, bright,
    output duty_r, duty_g, duty_b, phase, step_stb
  );
endinterface

// File: rtl/rgb_hue_sequencer.sv
// Colour-wheel generator for the RGB PWM duty inputs.
// It walks 6 linear phases of 255 steps, then applies brightness scaling and blanking.
module rgb_hue_sequencer #(
  parameter int unsigned STEP_DIV = 17_647
) (
  input  logic                 io_clk,
  input  logic                 io_resetn,
  rgb_hue_sequencer_if.slave   bus
);

  localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(STEP_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    level_q, level_d;
  logic [2:0]    phase_q, phase_d;
  logic          tick_q, tick_d;
  logic          stb_q, stb_d;
  logic [7:0]    duty_r_q, duty_r_d;
  logic [7:0]    duty_g_q, duty_g_d;
  logic [7:0]    duty_b_q, duty_b_d;
  logic [7:0]    raw_r, raw_g, raw_b;
  logic          tick;

  // The factor is bright+1, so 255 is unity gain and 0 yields (raw*1)>>8 = 0.
  function automatic logic [7:0] scale(input logic [7:0] raw, input logic [7:0] br);
    logic [16:0] prod;
    prod = 17'(raw) * 17'({1'b0, br} + 9'd1);
    return 8'(prod >> 8);
  endfunction

  always_comb begin
    tick    = bus.en && (presc_q == PreMax);
    presc_d = presc_q;
    level_d = level_q;
    phase_d = phase_q;
    if (bus.en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      if (level_q == 8'd254) begin
        level_d = 8'd0;
        phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      end else begin
        level_d = level_q + 8'd1;
      end
    end
  end

  always_comb begin
    raw_r = 8'd0;
    raw_g = 8'd0;
    raw_b = 8'd0;
    unique case (phase_q)
      3'd0: begin raw_r = 8'd255;           raw_g = level_q;          raw_b = 8'd0;             end
      3'd1: begin raw_r = 8'd255 - level_q; raw_g = 8'd255;           raw_b = 8'd0;             end
      3'd2: begin raw_r = 8'd0;             raw_g = 8'd255;           raw_b = level_q;          end
      3'd3: begin raw_r = 8'd0;             raw_g = 8'd255 - level_q; raw_b = 8'd255;           end
      3'd4: begin raw_r = level_q;          raw_g = 8'd0;             raw_b = 8'd255;           end
      3'd5: begin raw_r = 8'd255;           raw_g = 8'd0;             raw_b = 8'd255 - level_q; end
      default: ;
    endcase
  end

  // The strobe lags the tick by two edges so that it coincides with the duty update.
  always_comb begin
    tick_d   = tick;
    stb_d    = tick_q;
    duty_r_d = bus.blank ? 8'd0 : scale(raw_r, bus.bright);
    duty_g_d = bus.blank ? 8'd0 : scale(raw_g, bus.bright);
    duty_b_d = bus.blank ? 8'd0 : scale(raw_b, bus.bright);
  end

  always_ff @(posedge io_clk or negedge io_resetn) begin
    if (!io_resetn) begin
      presc_q  <= '0;
      level_q  <= 8'd0;
      phase_q  <= 3'd0;
      tick_q   <= 1'b0;
      stb_q    <= 1'b0;
      duty_r_q <= 8'd0;
      duty_g_q <= 8'd0;
      duty_b_q <= 8'd0;
    end else begin
      presc_q  <= presc_d;
      level_q  <= level_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      stb_q    <= stb_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
    end
  end

  assign bus.duty_r   = duty_r_q;
  assign bus.duty_g   = duty_g_q;
  assign bus.duty_b   = duty_b_q;
  assign bus.phase    = phase_q;
  assign bus.step_stb = stb_q;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Bench for rgb_hue_sequencer. It runs STEP_DIV=4 and STEP_DIV=1 instances in lockstep
// and checks both against a model that tracks a wheel position from 0 to 1529.
module tb_rgb_hue_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic [7:0] bright = 8'd255;

  int checks = 0;
  int failures = 0;

  rgb_hue_sequencer_if if4();
  rgb_hue_sequencer_if if1();

  assign if4.en = en;
  assign if4.blank = blank;
  assign if4.bright = bright;
  assign if1.en = en;
  assign if1.blank = blank;
  assign if1.bright = bright;

  rgb_hue_sequencer #(.STEP_DIV(4)) u_dut4 (.io_clk(clk), .io_resetn(rst_n), .bus(if4));
  rgb_hue_sequencer #(.STEP_DIV(1)) u_dut1 (.io_clk(clk), .io_resetn(rst_n), .bus(if1));

  always #5 clk = ~clk;

  int div [2] = '{4, 1};
  int cnt [2];
  int pos [2];
  bit tickd [2];
  int er [2];
  int eg [2];
  int eb [2];
  int ep [2];
  bit es [2];

  function automatic int raw_of(input int p, input int ch);
    int ph = p / 255;
    int l  = p % 255;
    int c [3];
    case (ph)
      0: c = '{255, l, 0};
      1: c = '{255 - l, 255, 0};
      2: c = '{0, 255, l};
      3: c = '{0, 255 - l, 255};
      4: c = '{l, 0, 255};
      default: c = '{255, 0, 255 - l};
    endcase
    return c[ch];
  endfunction

  function automatic int scl(input int raw, input int br);
    return (raw * (br + 1)) / 256;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; pos[d] = 0; tickd[d] = 1'b0;
      er[d] = 0; eg[d] = 0; eb[d] = 0; ep[d] = 0; es[d] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit tk;
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      er[d] = blank ? 0 : scl(raw_of(pos[d], 0), int'(bright));
      eg[d] = blank ? 0 : scl(raw_of(pos[d], 1), int'(bright));
      eb[d] = blank ? 0 : scl(raw_of(pos[d], 2), int'(bright));
      es[d] = tickd[d];
      tk = en && (cnt[d] == div[d] - 1);
      tickd[d] = tk;
      if (en) begin
        if (tk) begin
          cnt[d] = 0;
          pos[d] = (pos[d] + 1) % 1530;
        end else begin
          cnt[d]++;
        end
      end
      ep[d] = pos[d] / 255;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d4_duty_r", 32'(if4.duty_r), er[0]);
    chk("d4_duty_g", 32'(if4.duty_g), eg[0]);
    chk("d4_duty_b", 32'(if4.duty_b), eb[0]);
    chk("d4_phase", 32'(if4.phase), ep[0]);
    chk("d4_stb", 32'(if4.step_stb), 32'(es[0]));
    chk("d1_duty_r", 32'(if1.duty_r), er[1]);
    chk("d1_duty_g", 32'(if1.duty_g), eg[1]);
    chk("d1_duty_b", 32'(if1.duty_b), eb[1]);
    chk("d1_phase", 32'(if1.phase), ep[1]);
    chk("d1_stb", 32'(if1.step_stb), 32'(es[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int pr, pg, pb, dsum;
    model_reset();
    #2;
    check_all();
    repeat (3) step();

    // Release the reset mid-cycle while running at full brightness.
    en = 1'b1; blank = 1'b0; bright = 8'd255;
    rst_n = 1'b1;
    step();
    chk("first_r", 32'(if4.duty_r), 255);
    chk("first_g", 32'(if4.duty_g), 0);
    chk("first_phase", 32'(if4.phase), 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("early_stb", 32'(if4.step_stb), 0);
    end
    step();
    chk("edge5_g", 32'(if4.duty_g), 1);
    chk("edge5_stb", 32'(if4.step_stb), 1);
    step();
    chk("edge6_stb", 32'(if4.step_stb), 0);
    repeat (2) step();
    step();
    chk("edge9_stb", 32'(if4.step_stb), 1);

    // With STEP_DIV=1, each step must move exactly one channel by one LSB.
    pr = int'(if1.duty_r); pg = int'(if1.duty_g); pb = int'(if1.duty_b);
    for (int i = 0; i < 1600; i++) begin
      step();
      if (if1.step_stb) begin
        dsum = ((int'(if1.duty_r) > pr) ? int'(if1.duty_r) - pr : pr - int'(if1.duty_r))
             + ((int'(if1.duty_g) > pg) ? int'(if1.duty_g) - pg : pg - int'(if1.duty_g))
             + ((int'(if1.duty_b) > pb) ? int'(if1.duty_b) - pb : pb - int'(if1.duty_b));
        chk("one_channel_step", dsum, 1);
      end
      pr = int'(if1.duty_r); pg = int'(if1.duty_g); pb = int'(if1.duty_b);
    end

    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    repeat (20) step();

    blank = 1'b1;
    repeat (30) step();
    blank = 1'b0;
    repeat (10) step();

    bright = 8'd127;
    repeat (10) step();
    bright = 8'd0;
    repeat (5) step();
    bright = 8'd255;

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      if ($urandom_range(0, 7) == 0) bright = 8'($urandom_range(0, 255));
      step();
    end

    // Restart from phase 0, level 0 to check the brightness scaling against fixed values.
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1; bright = 8'd127; en = 1'b1; blank = 1'b0;
    step();
    chk("bright127_r", 32'(if4.duty_r), 127);
    bright = 8'd255;

    repeat (1100) step();
    chk("mid_phase4", 32'(if1.phase), 4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_r", 32'(if1.duty_r), 0);
    chk("async_b", 32'(if1.duty_b), 0);
    check_all();
    step();
    rst_n = 1'b1;
    step();
    chk("resume_r", 32'(if1.duty_r), 255);
    chk("resume_g", 32'(if1.duty_g), 0);
    chk("resume_b", 32'(if1.duty_b), 0);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
